// File: rtl/id_pkg.sv
// id_pkg: shared state encoding and ASCII constants for the identifier stream generator.
package id_pkg;
    typedef enum logic [1:0] {IDLE, LETTER, DIGIT, TERM} state_e;
    localparam logic [7:0] CH_A_LO  = 8'h61;
    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [4:0] LETTER_CNT = 5'd26;
    localparam logic [3:0] DIGIT_CNT  = 4'd10;
endpackage

// File: rtl/id_char_enc.sv
// id_char_enc: combinational map of (phase, index, upper) to the ASCII byte for that beat.
module id_char_enc
    import id_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = CH_SPACE
) (
    input  logic [1:0] phase,
    input  logic [4:0] idx,
    input  logic       upper,
    output logic [7:0] ch
);
    always_comb begin
        ch = (phase == LETTER) ? (upper ? CH_A_UP : CH_A_LO) + {3'b000, idx} :
             (phase == DIGIT)  ? CH_0 + {3'b000, idx} :
             (phase == TERM)   ? TERM_CHAR : 8'h00;
    end
endmodule

// File: rtl/id_stream_gen.sv
// id_stream_gen: emits letters, digits and a terminator as an ASCII stream per request.
// Optional uppercase letters via macro ID_STREAM_GEN_UPPER_EN (adds req_upper).
module id_stream_gen
    import id_pkg::*;
#(
    parameter int         LEN_W     = 4,
    parameter logic [7:0] TERM_CHAR = CH_SPACE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_letters,
    input  logic [LEN_W-1:0] req_digits,
    input  logic [4:0]       req_lseed,
    input  logic [3:0]       req_dseed,
`ifdef ID_STREAM_GEN_UPPER_EN
    input  logic             req_upper,
`endif
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             char_last,
    output logic             exp_id,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] lcnt_q, lcnt_d, dcnt_q, dcnt_d;
    logic [4:0]       lidx_q, lidx_d;
    logic [3:0]       didx_q, didx_d;
    logic             upper_q, upper_d, exp_id_q, exp_id_d;
    logic             upper_in, beat;

`ifdef ID_STREAM_GEN_UPPER_EN
    assign upper_in = req_upper;
`else
    assign upper_in = 1'b0;
`endif

    assign beat = char_valid && char_ready;

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        dcnt_d  = dcnt_q;
        lidx_d  = lidx_q;
        didx_d  = didx_q;
        upper_d = upper_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = LETTER;
                lcnt_d  = (req_letters == '0) ? LEN_W'(1) : req_letters;
                dcnt_d  = req_digits;
                lidx_d  = (req_lseed >= LETTER_CNT) ? 5'd0 : req_lseed;
                didx_d  = (req_dseed >= DIGIT_CNT) ? 4'd0 : req_dseed;
                upper_d = upper_in;
            end
            LETTER: if (beat) begin
                lidx_d = (lidx_q == LETTER_CNT - 5'd1) ? 5'd0 : lidx_q + 5'd1;
                lcnt_d = lcnt_q - LEN_W'(1);
                if (lcnt_q == LEN_W'(1)) state_d = (dcnt_q != '0) ? DIGIT : TERM;
            end
            DIGIT: if (beat) begin
                didx_d = (didx_q == DIGIT_CNT - 4'd1) ? 4'd0 : didx_q + 4'd1;
                dcnt_d = dcnt_q - LEN_W'(1);
                if (dcnt_q == LEN_W'(1)) state_d = TERM;
            end
            default: if (beat) state_d = IDLE;
        endcase
        exp_id_d = (state_d == DIGIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lcnt_q   <= '0;
            dcnt_q   <= '0;
            lidx_q   <= '0;
            didx_q   <= '0;
            upper_q  <= 1'b0;
            exp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lcnt_q   <= lcnt_d;
            dcnt_q   <= dcnt_d;
            lidx_q   <= lidx_d;
            didx_q   <= didx_d;
            upper_q  <= upper_d;
            exp_id_q <= exp_id_d;
        end
    end

    id_char_enc #(.TERM_CHAR(TERM_CHAR)) u_enc (
        .phase (state_q),
        .idx   ((state_q == DIGIT) ? {1'b0, didx_q} : lidx_q),
        .upper (upper_q),
        .ch    (char_out)
    );

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign char_valid = busy;
    assign char_last  = (state_q == TERM);
    assign exp_id     = exp_id_q;
endmodule

// File: tb/tb_id_stream_gen.sv
// tb_id_stream_gen: directed checks of the identifier stream generator with hand-derived char sequences.
module tb_id_stream_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_letters = '0;
    logic [3:0] req_digits = '0;
    logic [4:0] req_lseed = '0;
    logic [3:0] req_dseed = '0;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready = 1'b1;
    logic       char_last;
    logic       exp_id;
    logic       busy;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_c [0:40];

    always #5 clk = ~clk;

    id_stream_gen dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_letters(req_letters), .req_digits(req_digits), .req_lseed(req_lseed),
        .req_dseed(req_dseed), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .char_last(char_last), .exp_id(exp_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Builds the expected stream, issues the request and walks every beat.
    task automatic run(input int l, input int d, input int ls, input int ds, input bit stall, input bit junk);
        int nl, n, k, cyc, li, di;
        nl = (l == 0) ? 1 : l;
        n  = nl + d + 1;
        li = (ls > 25) ? 0 : ls;
        di = (ds > 9) ? 0 : ds;
        for (int i = 0; i < nl; i++) exp_c[i] = 8'h61 + 8'((li + i) % 26);
        for (int i = 0; i < d; i++) exp_c[nl+i] = 8'h30 + 8'((di + i) % 10);
        exp_c[n-1] = 8'h20;
        chk("req_ready_idle", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1;
        req_letters = 4'(l);
        req_digits = 4'(d);
        req_lseed = 5'(ls);
        req_dseed = 4'(ds);
        @(negedge clk);
        if (!junk) req_valid = 1'b0;
        req_letters = 4'd7;
        req_digits = 4'd7;
        req_lseed = 5'd3;
        req_dseed = 4'd3;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            char_ready = stall ? (cyc % 3 == 0) : 1'b1;
            chk("char_valid", {7'd0, char_valid}, 8'd1);
            chk($sformatf("char_out[%0d]", k), char_out, exp_c[k]);
            chk("char_last", {7'd0, char_last}, {7'd0, k == n - 1});
            chk("exp_id", {7'd0, exp_id}, {7'd0, k >= nl && k < n - 1});
            chk("busy", {7'd0, busy}, 8'd1);
            chk("req_ready_busy", {7'd0, req_ready}, 8'd0);
            if (char_ready) k++;
            cyc++;
            if (k == n) req_valid = 1'b0;
            @(negedge clk);
        end
        chk("stream_done", 8'(k), 8'(n));
        char_ready = 1'b1;
        chk("req_ready_after", {7'd0, req_ready}, 8'd1);
        chk("char_valid_after", {7'd0, char_valid}, 8'd0);
        chk("busy_after", {7'd0, busy}, 8'd0);
        chk("exp_id_after", {7'd0, exp_id}, 8'd0);
    endtask

    initial begin
        #2;
        chk("rst_req_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_char_valid", {7'd0, char_valid}, 8'd0);
        chk("rst_char_out", char_out, 8'h00);
        chk("rst_char_last", {7'd0, char_last}, 8'd0);
        chk("rst_exp_id", {7'd0, exp_id}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(3, 2, 0, 0, 1'b0, 1'b1);
        run(2, 0, 25, 0, 1'b0, 1'b0);
        run(0, 12, 0, 8, 1'b0, 1'b0);
        run(4, 1, 0, 0, 1'b1, 1'b0);
        run(15, 15, 30, 13, 1'b1, 1'b0);
        run(1, 3, 7, 5, 1'b0, 1'b0);
        // reset in the middle of the digit phase
        req_valid = 1'b1;
        req_letters = 4'd1;
        req_digits = 4'd5;
        req_lseed = 5'd2;
        req_dseed = 4'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_exp_id", {7'd0, exp_id}, 8'd1);
        chk("mid_char", char_out, 8'h35);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_char_valid", {7'd0, char_valid}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_req_ready", {7'd0, req_ready}, 8'd1);
        chk("arst_char_out", char_out, 8'h00);
        chk("arst_exp_id", {7'd0, exp_id}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(2, 2, 24, 9, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
